// File: rtl/wfs_pkg.sv
// Shared types and constants for the waveform streamer.
package wfs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    PLAY
  } wfs_state_t;

  localparam int SAMPLE_W  = 8;
  localparam int FRAME_LEN = 256;
  localparam int IDX_W     = 8;

endpackage

// File: rtl/wfs_tick_gen.sv
// Sample-rate divider: counts 0..div_l-1 while running and emits a
// one-cycle tick on the terminal count, then wraps to zero.
module wfs_tick_gen
  import wfs_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] div_l,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic             at_end;

  assign at_end = (cnt == (div_l - DIV_W'(1)));
  assign tick   = run && at_end;

  // Divider counter; cleared on frame capture, advances only during playback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= at_end ? '0 : (cnt + DIV_W'(1));
    end
  end

endmodule

// File: rtl/waveform_streamer.sv
// Frame reader and sample player for the waveform converter.
// Requests a frame, snapshots it into a local buffer, then plays it out one
// sample per divider tick over a valid/ready handshake.
// Optional macro WFS_UNDERRUN_CNT_EN enables the saturating dropped-tick
// counter on underrun_cnt; without it underrun_cnt is tied to zero.
module waveform_streamer
  import wfs_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int FRAME_LEN = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DIV_W-1:0]    div,
  output logic                start_flg,
  input  logic                rdy_flg,
  input  logic [SAMPLE_W-1:0] frame [FRAME_LEN],
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_vld,
  input  logic                sample_rdy,
  output logic                frame_done,
  output logic                busy,
  output logic [15:0]         underrun_cnt
);

  wfs_state_t          state;
  wfs_state_t          next_state;
  logic [SAMPLE_W-1:0] frame_buf [FRAME_LEN];
  logic [DIV_W-1:0]    div_l;
  logic [IDX_W-1:0]    idx;
  logic                last_pend;
  logic                tick;
  logic                capture;
  logic                accept;
  logic                frame_end;

  assign capture   = (state == WAIT) && rdy_flg;
  assign accept    = sample_vld && sample_rdy;
  assign frame_end = (state == PLAY) && accept && last_pend;
  assign start_flg = (state == REQ);
  assign busy      = (state != IDLE);

  wfs_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (capture),
    .run  (state == PLAY),
    .div_l(div_l),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; en is only looked at in IDLE and at the frame boundary.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (en) next_state = REQ;
      REQ:  next_state = WAIT;
      WAIT: if (rdy_flg) next_state = PLAY;
      PLAY: if (frame_end) next_state = en ? REQ : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Frame snapshot; only written while waiting so converter updates during
  // playback never disturb the samples being played. No reset needed.
  always_ff @(posedge clk) begin
    if (capture) begin
      frame_buf <= frame;
    end
  end

  // Playback datapath: issue on a free tick, hold under backpressure, and
  // finish the frame once the last sample is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_out <= '0;
      sample_vld <= 1'b0;
      frame_done <= 1'b0;
      idx        <= '0;
      last_pend  <= 1'b0;
      div_l      <= DIV_W'(1);
    end else begin
      frame_done <= 1'b0;
      if (capture) begin
        div_l     <= (div == '0) ? DIV_W'(1) : div;
        idx       <= '0;
        last_pend <= 1'b0;
      end else if (state == PLAY) begin
        if (frame_end) begin
          sample_vld <= 1'b0;
          last_pend  <= 1'b0;
          frame_done <= 1'b1;
        end else if (tick && (!sample_vld || sample_rdy)) begin
          sample_out <= frame_buf[idx];
          sample_vld <= 1'b1;
          idx        <= idx + IDX_W'(1);
          last_pend  <= (idx == {IDX_W{1'b1}});
        end else if (accept) begin
          sample_vld <= 1'b0;
        end
      end
    end
  end

`ifdef WFS_UNDERRUN_CNT_EN
  logic dropped;

  assign dropped = tick && sample_vld && !sample_rdy;

  // Saturating count of ticks lost to downstream backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (dropped && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_waveform_streamer.sv
// Scoreboard bench for waveform_streamer: the converter model pushes each
// delivered frame into an expected queue and a monitor pops on every accepted
// sample.
module tb_waveform_streamer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] div;
  logic        start_flg;
  logic        rdy_flg;
  logic [7:0]  conv_frame [256];
  logic [7:0]  sample_out;
  logic        sample_vld;
  logic        sample_rdy;
  logic        frame_done;
  logic        busy;
  logic [15:0] underrun_cnt;

  int          checks;
  int          failures;
  logic [7:0]  exp_q [$];
  int          cycle;
  int          in_frame;
  int          last_accept;
  int          exp_gap;
  int          done_cnt;
  int          start_cnt;
  logic        held_valid;
  logic [7:0]  held_val;
  logic        prev_start;

  waveform_streamer #(
    .DIV_W    (16),
    .FRAME_LEN(256)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .div         (div),
    .start_flg   (start_flg),
    .rdy_flg     (rdy_flg),
    .frame       (conv_frame),
    .sample_out  (sample_out),
    .sample_vld  (sample_vld),
    .sample_rdy  (sample_rdy),
    .frame_done  (frame_done),
    .busy        (busy),
    .underrun_cnt(underrun_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 256; i++) conv_frame[i] = 8'(i);
  endtask

  task automatic load_ones();
    for (int i = 0; i < 256; i++) conv_frame[i] = 8'hFF;
  endtask

  task automatic wait_in_frame(input int n, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (in_frame >= n) begin
        seen = 1'b1;
        break;
      end
    end
    check_output(name, int'(seen), 1);
  endtask

  task automatic wait_frame_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    check_output(name, int'(seen), 1);
  endtask

  // Converter model: on a request, drop rdy, raise it one edge later and
  // record the frame it is presenting as the expected playback.
  initial begin
    rdy_flg = 1'b0;
    forever begin
      @(negedge clk);
      if (start_flg) begin
        rdy_flg = 1'b0;
        @(posedge clk);
        #1;
        rdy_flg = 1'b1;
        for (int i = 0; i < 256; i++) exp_q.push_back(conv_frame[i]);
      end
    end
  end

  // Monitor: compare accepted samples, spacing, hold stability and frame size.
  initial begin
    cycle       = 0;
    in_frame    = 0;
    last_accept = 0;
    done_cnt    = 0;
    start_cnt   = 0;
    held_valid  = 1'b0;
    held_val    = '0;
    prev_start  = 1'b0;
    forever begin
      @(negedge clk);
      cycle++;
      if (!rst) begin
        if (held_valid) begin
          check_output("hold_vld", int'(sample_vld), 1);
          check_output("hold_data", int'(sample_out), int'(held_val));
        end
        if (sample_vld && sample_rdy) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_sample", 1, 0);
          end else begin
            check_output($sformatf("sample_%0d", in_frame), int'(sample_out), int'(exp_q.pop_front()));
          end
          if (exp_gap != 0 && in_frame > 0) check_output("sample_gap", cycle - last_accept, exp_gap);
          last_accept = cycle;
          in_frame++;
        end
        held_valid = sample_vld && !sample_rdy;
        held_val   = sample_out;
        if (frame_done) begin
          check_output("frame_len", in_frame, 256);
          in_frame = 0;
          done_cnt++;
        end
        if (start_flg) begin
          check_output("start_single", int'(prev_start), 0);
          start_cnt++;
        end
        prev_start = start_flg;
      end else begin
        held_valid = 1'b0;
        prev_start = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hits;
    checks     = 0;
    failures   = 0;
    exp_gap    = 0;
    rst        = 1'b1;
    en         = 1'b0;
    div        = 16'd4;
    sample_rdy = 1'b1;
    load_ramp();

    // Reset values
    #2;
    check_output("rst_start_flg", int'(start_flg), 0);
    check_output("rst_sample_out", int'(sample_out), 0);
    check_output("rst_sample_vld", int'(sample_vld), 0);
    check_output("rst_frame_done", int'(frame_done), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_underrun", int'(underrun_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic ramp at div 4, frame isolation, back-to-back request, stop at boundary
    exp_gap = 4;
    en = 1'b1;
    wait_in_frame(20, "t1_reach_20");
    check_output("t1_busy", int'(busy), 1);
    load_ones();
    wait_frame_done("t1_done_1");
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (start_cnt >= 2) hits = 1;
    end
    check_output("t1_next_start", hits, 1);
    wait_in_frame(100, "t1_reach_100");
    en = 1'b0;
    load_ramp();
    wait_frame_done("t1_done_2");
    repeat (20) @(posedge clk);
    #1;
    check_output("t1_idle_busy", int'(busy), 0);
    check_output("t1_start_cnt", start_cnt, 2);
    check_output("t1_done_cnt", done_cnt, 2);
    check_output("t1_q_empty", exp_q.size(), 0);
    check_output("t1_underrun", int'(underrun_cnt), 0);

    // Backpressure at div 2 while sample 10 is held
    exp_gap = 0;
    div = 16'd2;
    en = 1'b1;
    hits = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (sample_vld && sample_out == 8'd10) begin
        hits = 1;
        break;
      end
    end
    check_output("bp_found_10", hits, 1);
    sample_rdy = 1'b0;
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_output("bp_held_vld", int'(sample_vld), 1);
    check_output("bp_held_data", int'(sample_out), 10);
    sample_rdy = 1'b1;
    wait_frame_done("bp_done");
`ifdef WFS_UNDERRUN_CNT_EN
    check_output("bp_underrun", int'(underrun_cnt), 2);
`else
    check_output("bp_underrun", int'(underrun_cnt), 0);
`endif
    repeat (4) @(posedge clk);
    #1;
    check_output("bp_q_empty", exp_q.size(), 0);
    check_output("bp_busy", int'(busy), 0);

    // Zero divider behaves as one sample per clock
    exp_gap = 1;
    div = 16'd0;
    en = 1'b1;
    wait_in_frame(1, "z_first");
    en = 1'b0;
    wait_frame_done("z_done");
    repeat (4) @(posedge clk);
    #1;
    exp_gap = 0;
    check_output("z_q_empty", exp_q.size(), 0);
    check_output("z_done_cnt", done_cnt, 4);

    // Reset in the middle of playback
    div = 16'd3;
    en = 1'b1;
    hits = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (sample_vld && sample_out == 8'd50) begin
        hits = 1;
        break;
      end
    end
    check_output("r_found_50", hits, 1);
    #2;
    rst = 1'b1;
    #1;
    check_output("r_sample_vld", int'(sample_vld), 0);
    check_output("r_sample_out", int'(sample_out), 0);
    check_output("r_busy", int'(busy), 0);
    check_output("r_start_flg", int'(start_flg), 0);
    check_output("r_frame_done", int'(frame_done), 0);
    check_output("r_underrun", int'(underrun_cnt), 0);
    exp_q.delete();
    in_frame = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_in_frame(1, "r_restart");
    en = 1'b0;
    wait_frame_done("r_done");
    repeat (4) @(posedge clk);
    #1;
    check_output("r_q_empty", exp_q.size(), 0);
    check_output("total_done", done_cnt, 5);
    check_output("total_start", start_cnt, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
